uart_block_rx: RTL

- Serial-to-block receive front end that sits directly upstream of the two-round encrypt stage.
- Deserialises 8N1 UART bytes from the host and assembles 16 bytes into one 128-bit plaintext block.
- Presents the block on data and asserts data_state for one clock to launch encryption.
- Discards partial blocks on line idle timeout and drops malformed bytes.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 171 +++++++++++++++++
 rtl/uart_block_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and bit-FSM state encoding for the UART block
// receiver (uart_rx_byte, uart_block_rx).
//   BLOCK_BYTES           bytes per assembled plaintext block
//   DEFAULT_CLOCK_PER_BIT clk cycles per bit (100 MHz / 9600 baud)
//   state_t               receive FSM states; PARITY is only entered when
//                         UART_RX_PARITY_EN is defined
package uart_pkg;

  localparam int BLOCK_BYTES           = 16;
  localparam int DEFAULT_CLOCK_PER_BIT = 10417;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop synchroniser plus bit-level FSM that turns one UART
// frame into a byte.
// Optional feature: macro UART_RX_PARITY_EN adds an even-parity bit after
// data bit 7 (PARITY state); without it the frame is pure 8N1.
// Ports:
//   clk, rst    system clock, async active-high reset
//   rx          raw serial line (idles high)
//   byte_data   last received byte (LSB received first)
//   byte_valid  1-cycle strobe: byte_data holds a well-framed byte
//   byte_err    1-cycle strobe: byte rejected (stop bit 0 or parity error)
//   start_det   1-cycle strobe: falling edge seen in IDLE
//   state       current FSM state (state_t encoding) for observation
// Handshake: byte_valid/byte_err/start_det are strobes with no ready;
// the consumer must act on them in the cycle they are high.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = DEFAULT_CLOCK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       start_det,
  output logic [2:0] state
);

  localparam int CW = $clog2(CLOCK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCK_PER_BIT - 1);

  logic rx_m, rx_s, rx_p;
  logic fall;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic          par_err_q, par_err_d;
`endif

  // Synchroniser and previous-value flop reset high so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign fall = rx_p & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    start_det  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          start_det = 1'b1;
          state_d   = START;
          cnt_d     = '0;
          idx_d     = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      START: begin
        // Mid-start-bit check: a line back high here was only a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: data ones plus parity bit must be even.
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            byte_valid = ~par_err_q;
            byte_err   = par_err_q;
`else
            byte_valid = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            byte_err = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must return high before a new start.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shift_q;
  assign state     = state_q;

endmodule

// File: rtl/uart_block_rx.sv
// uart_block_rx: assembles 16 UART bytes into one 128-bit plaintext block
// for the encrypt stage. Partial blocks are dropped after an idle timeout.
// Optional feature: macro UART_RX_PARITY_EN (even parity, see uart_rx_byte).
// Ports:
//   clk, rst    system clock, async active-high reset
//   rx          raw serial line (idles high)
//   data        last complete block, first byte in [127:120]
//   data_state  1-cycle strobe: data holds a new block (no backpressure)
//   frame_err   1-cycle strobe: a byte was rejected
//   timeout     1-cycle strobe: partial block discarded
//   byte_cnt    bytes accepted into the current block, 0..15
module uart_block_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = DEFAULT_CLOCK_PER_BIT,
  parameter int TIMEOUT_BITS  = 160
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  output logic [127:0] data,
  output logic         data_state,
  output logic         frame_err,
  output logic         timeout,
  output logic [4:0]   byte_cnt
);

  localparam int TO_CYCLES = TIMEOUT_BITS * CLOCK_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);
  localparam logic [4:0]    LAST_BYTE = 5'(BLOCK_BYTES - 1);

  logic [7:0]    byte_data;
  logic          byte_valid, byte_err, start_det;
  logic [2:0]    rx_state;
  logic [119:0]  block_q;    // the first 15 bytes; the 16th joins on load
  logic [TW-1:0] tcnt_q;
  logic          counting, expire;

  uart_rx_byte #(
    .CLOCK_PER_BIT(CLOCK_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .start_det (start_det),
    .state     (rx_state)
  );

  // Idle timer only runs between bytes of a partially filled block.
  assign counting = (byte_cnt != 5'd0) && (rx_state == IDLE);
  // Expiry ignores start_det so a start edge in the expiry cycle still
  // discards the old block and begins a fresh one.
  assign expire   = counting && (tcnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      data_state <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      byte_cnt   <= '0;
      block_q    <= '0;
      tcnt_q     <= '0;
    end else begin
      data_state <= 1'b0;
      frame_err  <= byte_err;
      timeout    <= 1'b0;

      if (expire) begin
        byte_cnt <= '0;
        block_q  <= '0;
        timeout  <= 1'b1;
        tcnt_q   <= '0;
      end else if (start_det) begin
        tcnt_q <= '0;
      end else if (counting) begin
        tcnt_q <= tcnt_q + 1'b1;
      end

      // byte_valid only occurs in STOP, so it never coincides with expire.
      if (byte_valid) begin
        if (byte_cnt == LAST_BYTE) begin
          data       <= {block_q, byte_data};
          data_state <= 1'b1;
          byte_cnt   <= '0;
          block_q    <= '0;
        end else begin
          block_q  <= {block_q[111:0], byte_data};
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule
